// File: rtl/dtw_result_collector_if.sv
// Purpose : bundles the result-FIFO read port and the AXI-Stream output of the collector.
// Ports   : res_fifo_rden/empty/data (FIFO side), m_axis_tdata/tvalid/tready/tlast (stream side).
// Modports: master = collector view, slave = FIFO + downstream sink view.
interface dtw_result_collector_if #(
  parameter int AXIS_WIDTH = 32
);
  logic                  res_fifo_rden;
  logic                  res_fifo_empty;
  logic [31:0]           res_fifo_data;
  logic [AXIS_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output res_fifo_rden,
    input  res_fifo_empty,
    input  res_fifo_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    input  res_fifo_rden,
    output res_fifo_empty,
    output res_fifo_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
endinterface

// File: rtl/dtw_result_collector.sv
// Purpose : drains 3-word DTW result records, screens minval against a threshold, re-emits
//           passing records as 3-beat AXI-Stream packets and tracks best-hit/count status.
// Latency : first rden at t -> EVAL at t+4 -> first beat valid at t+5.
// Backpressure: beats hold until tready; FIFO reads stall while the FIFO is empty.
// Ports   : clk, rst_n (async, active-low), en, clear, score_thresh; bus (FIFO + AXIS,
//           master modport); status outputs rec_count, drop_count, best_*, fmt_err.
module dtw_result_collector #(
  parameter int WIDTH      = 16,
  parameter int AXIS_WIDTH = 32,
  parameter bit FILTER_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       score_thresh,
  dtw_result_collector_if.master bus,
  output logic [31:0]            rec_count,
  output logic [31:0]            drop_count,
  output logic [31:0]            best_qid,
  output logic [31:0]            best_pos,
  output logic [WIDTH-1:0]       best_minval,
  output logic                   best_valid,
  output logic                   fmt_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, SEND} state_t;

  state_t                state;
  logic [1:0]            req_cnt;   // reads issued for the current record
  logic [1:0]            cap_cnt;   // words captured for the current record
  logic                  rd_pend;   // a read was issued last cycle; its data is on the bus now
  logic [1:0]            beat;
  logic [31:0]           cap_qid;
  logic [31:0]           cap_pos;
  logic [31:0]           cap_val;
  logic [AXIS_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;

  logic                  rden;
  logic [WIDTH-1:0]      minval;
  logic                  val_hi_bad;
  logic                  drop;
  logic                  better;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rden       = (state == FETCH) && !bus.res_fifo_empty && (req_cnt != 2'd3);
  assign minval     = cap_val[WIDTH-1:0];
  // Shifting by WIDTH also covers WIDTH == 32, where no upper bits exist.
  assign val_hi_bad = ((cap_val >> WIDTH) != 32'd0);
  assign drop       = FILTER_EN && (minval > score_thresh);
  // Strict compare: a tie keeps the record that arrived first.
  assign better     = !best_valid || (minval < best_minval);

  assign bus.res_fifo_rden = rden;
  assign bus.m_axis_tdata  = tdata;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tlast  = tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_cnt     <= 2'd0;
      cap_cnt     <= 2'd0;
      rd_pend     <= 1'b0;
      beat        <= 2'd0;
      cap_qid     <= 32'd0;
      cap_pos     <= 32'd0;
      cap_val     <= 32'd0;
      tdata       <= '0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      rec_count   <= 32'd0;
      drop_count  <= 32'd0;
      best_qid    <= 32'd0;
      best_pos    <= 32'd0;
      best_minval <= '0;
      best_valid  <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      rd_pend <= rden;
      if (rden) req_cnt <= req_cnt + 2'd1;

      case (state)
        IDLE: begin
          if (en) begin
            state   <= FETCH;
            req_cnt <= 2'd0;
            cap_cnt <= 2'd0;
          end
        end
        FETCH: begin
          if (rd_pend) begin
            case (cap_cnt)
              2'd0:    cap_qid <= bus.res_fifo_data;
              2'd1:    cap_pos <= bus.res_fifo_data;
              default: cap_val <= bus.res_fifo_data;
            endcase
            cap_cnt <= cap_cnt + 2'd1;
            if (cap_cnt == 2'd2) state <= EVAL;
          end
        end
        EVAL: begin
          if (drop) begin
            state <= IDLE;
          end else begin
            state  <= SEND;
            beat   <= 2'd0;
            tvalid <= 1'b1;
            tlast  <= 1'b0;
            tdata  <= AXIS_WIDTH'(cap_qid);
          end
        end
        SEND: begin
          if (tvalid && bus.m_axis_tready) begin
            case (beat)
              2'd0: begin
                tdata <= AXIS_WIDTH'(cap_pos);
                beat  <= 2'd1;
              end
              2'd1: begin
                tdata <= AXIS_WIDTH'(minval);
                tlast <= 1'b1;
                beat  <= 2'd2;
              end
              default: begin
                tvalid <= 1'b0;
                tlast  <= 1'b0;
                state  <= IDLE;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase

      // Status: clear wins over a same-cycle EVAL; the packet path above is unaffected.
      if (clear) begin
        rec_count   <= 32'd0;
        drop_count  <= 32'd0;
        best_qid    <= 32'd0;
        best_pos    <= 32'd0;
        best_minval <= '0;
        best_valid  <= 1'b0;
        fmt_err     <= 1'b0;
      end else if (state == EVAL) begin
        rec_count <= sat_inc(rec_count);
        if (val_hi_bad) fmt_err <= 1'b1;
        if (better) begin
          best_qid    <= cap_qid;
          best_pos    <= cap_pos;
          best_minval <= minval;
          best_valid  <= 1'b1;
        end
        if (drop) drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_dtw_result_collector.sv
// Purpose : self-checking bench for dtw_result_collector: FIFO model, stream monitor,
//           record-level reference model, table vectors and hand-written corner sequences.
// Ports   : none (top-level bench).
module tb_dtw_result_collector;
  localparam int WIDTH      = 16;
  localparam int AXIS_WIDTH = 32;
  localparam int LIMIT      = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] score_thresh = '0;
  logic [31:0]      rec_count, drop_count, best_qid, best_pos;
  logic [WIDTH-1:0] best_minval;
  logic             best_valid, fmt_err;

  dtw_result_collector_if #(.AXIS_WIDTH(AXIS_WIDTH)) bus ();

  dtw_result_collector #(.WIDTH(WIDTH), .AXIS_WIDTH(AXIS_WIDTH), .FILTER_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .score_thresh(score_thresh), .bus(bus),
    .rec_count(rec_count), .drop_count(drop_count), .best_qid(best_qid), .best_pos(best_pos),
    .best_minval(best_minval), .best_valid(best_valid), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // ---------------- result FIFO model (1-cycle read latency) ----------------
  logic [31:0] fmem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign bus.res_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.res_fifo_rden) begin
      bus.res_fifo_data <= fmem[rd_ptr];
      rd_ptr            <= rd_ptr + 8'd1;
    end
  end

  task automatic push_word(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // ---------------- tready driver: 0 = hold low, 1 = hold high, 2 = random ----------------
  int tmode = 1;
  initial begin
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tmode)
        0:       bus.m_axis_tready = 1'b0;
        1:       bus.m_axis_tready = 1'b1;
        default: bus.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model: one call per complete record ----------------
  logic [AXIS_WIDTH:0] exp_q[$];   // {tlast, tdata}
  logic [31:0]         m_rec, m_drop, m_bq, m_bp;
  logic [WIDTH-1:0]    m_bmin;
  logic                m_bv, m_fmt;
  int                  m_pass;

  function automatic void model_clear();
    m_rec = 0; m_drop = 0; m_bq = 0; m_bp = 0; m_bmin = 0; m_bv = 0; m_fmt = 0;
  endfunction

  function automatic void model_rec(input logic [31:0] q, input logic [31:0] p,
                                    input logic [31:0] v, input logic [WIDTH-1:0] th);
    logic [WIDTH-1:0] mv;
    mv = v[WIDTH-1:0];
    m_rec++;
    if (v[31:WIDTH] != 0) m_fmt = 1'b1;
    if (!m_bv || mv < m_bmin) begin
      m_bq = q; m_bp = p; m_bmin = mv; m_bv = 1'b1;
    end
    if (mv > th) m_drop++;
    else begin
      m_pass++;
      exp_q.push_back({1'b0, AXIS_WIDTH'(q)});
      exp_q.push_back({1'b0, AXIS_WIDTH'(p)});
      exp_q.push_back({1'b1, AXIS_WIDTH'(mv)});
    end
  endfunction

  task automatic push_rec(input logic [31:0] q, input logic [31:0] p, input logic [31:0] v);
    push_word(q); push_word(p); push_word(v);
    model_rec(q, p, v, score_thresh);
  endtask

  // ---------------- stream monitor (samples on negedge) ----------------
  int                    tlast_cnt = 0;
  logic                  hold = 1'b0;
  logic [AXIS_WIDTH-1:0] hold_data;
  logic                  hold_last;

  always @(negedge clk) begin
    logic [AXIS_WIDTH:0] e;
    if (!rst_n) hold = 1'b0;
    else begin
      if (bus.res_fifo_rden) check("rden_while_empty", 64'(bus.res_fifo_empty), 64'd0);
      if (hold) begin
        check("tvalid_held", 64'(bus.m_axis_tvalid), 64'd1);
        check("tdata_stable", 64'(bus.m_axis_tdata), 64'(hold_data));
        check("tlast_stable", 64'(bus.m_axis_tlast), 64'(hold_last));
      end
      if (bus.m_axis_tvalid) begin
        if (bus.m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", bus.m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            if (bus.m_axis_tdata !== e[AXIS_WIDTH-1:0] || bus.m_axis_tlast !== e[AXIS_WIDTH]) begin
              errors++;
              $display("FAIL beat actual=%0h/%0b required=%0h/%0b", bus.m_axis_tdata,
                       bus.m_axis_tlast, e[AXIS_WIDTH-1:0], e[AXIS_WIDTH]);
            end
          end
          if (bus.m_axis_tlast) tlast_cnt++;
          hold = 1'b0;
        end else begin
          hold = 1'b1; hold_data = bus.m_axis_tdata; hold_last = bus.m_axis_tlast;
        end
      end else hold = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic drain(input string name);
    int n = 0;
    while (!(bus.res_fifo_empty && exp_q.size() == 0 && !bus.m_axis_tvalid) && n < LIMIT) begin
      @(negedge clk); n++;
    end
    check({name, "_timeout"}, 64'(n < LIMIT), 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rec_count"}, 64'(rec_count), 64'(m_rec));
    check({tag, "_drop_count"}, 64'(drop_count), 64'(m_drop));
    check({tag, "_best_qid"}, 64'(best_qid), 64'(m_bq));
    check({tag, "_best_pos"}, 64'(best_pos), 64'(m_bp));
    check({tag, "_best_minval"}, 64'(best_minval), 64'(m_bmin));
    check({tag, "_best_valid"}, 64'(best_valid), 64'(m_bv));
    check({tag, "_fmt_err"}, 64'(fmt_err), 64'(m_fmt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"}, 64'(bus.res_fifo_rden), 64'd0);
    check({tag, "_tvalid"}, 64'(bus.m_axis_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(bus.m_axis_tlast), 64'd0);
    check({tag, "_tdata"}, 64'(bus.m_axis_tdata), 64'd0);
    check({tag, "_rec_count"}, 64'(rec_count), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    check({tag, "_best"}, {best_qid, best_pos}, 64'd0);
    check({tag, "_best_minval"}, 64'(best_minval), 64'd0);
    check({tag, "_best_valid"}, 64'(best_valid), 64'd0);
    check({tag, "_fmt_err"}, 64'(fmt_err), 64'd0);
  endtask

  task automatic clear_pulse();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic             clr;
    logic [31:0]      q, p, v;
    logic [WIDTH-1:0] th;
    logic [31:0]      e_rec, e_drop, e_bq, e_bp;
    logic [WIDTH-1:0] e_bmin;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    int   n, m, pass0;
    tbl[0] = '{1'b1, 32'd9, 32'd5,  32'd60, 16'd50, 32'd1, 32'd1, 32'd9, 32'd5,  16'd60};
    tbl[1] = '{1'b1, 32'd1, 32'd11, 32'd30, 16'd50, 32'd1, 32'd0, 32'd1, 32'd11, 16'd30};
    tbl[2] = '{1'b0, 32'd2, 32'd22, 32'd30, 16'd50, 32'd2, 32'd0, 32'd1, 32'd11, 16'd30};
    tbl[3] = '{1'b0, 32'd3, 32'd33, 32'd20, 16'd50, 32'd3, 32'd0, 32'd3, 32'd33, 16'd20};
    model_clear();
    m_pass = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic record with first-read to first-beat latency.
    tmode = 1;
    score_thresh = 16'd50;
    push_rec(32'd7, 32'd100, 32'd42);
    @(negedge clk);
    en = 1'b1;
    n = 0;
    while (!bus.res_fifo_rden && n < 20) begin @(negedge clk); n++; end
    check("first_rden_seen", 64'(bus.res_fifo_rden), 64'd1);
    m = 0;
    while (!bus.m_axis_tvalid && m < 20) begin @(negedge clk); m++; end
    check("rden_to_tvalid_latency", 64'(m), 64'd5);
    drain("basic");
    check("basic_rec_count", 64'(rec_count), 64'd1);
    check("basic_best", {best_qid, best_pos}, {32'd7, 32'd100});
    check("basic_best_minval", 64'(best_minval), 64'd42);
    check_model("basic");

    // Table: drop, ties and a new best.
    foreach (tbl[i]) begin
      if (tbl[i].clr) clear_pulse();
      score_thresh = tbl[i].th;
      push_rec(tbl[i].q, tbl[i].p, tbl[i].v);
      drain("tbl");
      check("tbl_rec_count", 64'(rec_count), 64'(tbl[i].e_rec));
      check("tbl_drop_count", 64'(drop_count), 64'(tbl[i].e_drop));
      check("tbl_best", {best_qid, best_pos}, {tbl[i].e_bq, tbl[i].e_bp});
      check("tbl_best_minval", 64'(best_minval), 64'(tbl[i].e_bmin));
      check("tbl_best_valid", 64'(best_valid), 64'd1);
    end

    // FIFO runs dry after two words; the minval word carries stray upper bits.
    clear_pulse();
    score_thresh = 16'd50;
    push_word(32'd44);
    push_word(32'd55);
    repeat (20) @(negedge clk);
    check("stall_no_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("stall_rec_count", 64'(rec_count), 64'd0);
    push_word(32'h0001_0005);
    model_rec(32'd44, 32'd55, 32'h0001_0005, score_thresh);
    drain("stall");
    check("stall_fmt_err", 64'(fmt_err), 64'd1);
    check("stall_best_minval", 64'(best_minval), 64'd5);
    check_model("stall");

    // Random backpressure with random records against the model.
    tmode = 2;
    tlast_cnt = 0;
    pass0 = m_pass;
    score_thresh = 16'($urandom_range(20, 80));
    for (int i = 0; i < 24; i++) begin
      logic [31:0] v;
      v = 32'($urandom_range(0, 100));
      if ($urandom_range(0, 7) == 0) v = v | 32'h0003_0000;
      push_rec(32'(100 + i), $urandom, v);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    drain("random");
    check("random_tlast_count", 64'(tlast_cnt), 64'(m_pass - pass0));
    check_model("random");

    // Reset while beat 1 is stalled.
    tmode = 0;
    score_thresh = 16'd50;
    push_rec(32'hAA, 32'hBB, 32'h10);
    n = 0;
    while (!bus.m_axis_tvalid && n < 40) begin @(negedge clk); n++; end
    check("rst_beat0_valid", 64'(bus.m_axis_tvalid), 64'd1);
    tmode = 1;
    @(negedge clk);
    tmode = 0;
    @(negedge clk);
    check("rst_beat1_data", 64'(bus.m_axis_tdata), 64'hBB);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_all_zero("midsend_reset");
    exp_q.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // clear in the EVAL cycle: packet still goes out, status stays empty.
    tmode = 1;
    push_rec(32'd21, 32'd22, 32'd23);
    @(negedge clk);
    en = 1'b1;
    n = 0;
    while (!bus.res_fifo_rden && n < 20) begin @(negedge clk); n++; end
    check("clr_rden_seen", 64'(bus.res_fifo_rden), 64'd1);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    drain("clr_eval");
    check("clr_eval_rec_count", 64'(rec_count), 64'd0);
    check("clr_eval_best_valid", 64'(best_valid), 64'd0);
    check_model("clr_eval");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
